// File: rtl/counter_ctrl_pkg.sv
// Shared types for the counter sweep controller: FSM states, sweep modes
// and the counter direction encoding.
package counter_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RUN_UP   = 3'd1,
        RUN_DOWN = 3'd2,
        PAUSED   = 3'd3,
        DONE     = 3'd4
    } sweep_state_t;

    typedef enum logic {
        SINGLE = 1'b0,
        BOUNCE = 1'b1
    } sweep_mode_t;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/counter_tick_gen.sv
// Step-rate prescaler: counts 0..div_i while enabled and emits tick_o on
// the cycle the count equals div_i, then wraps. clr_i forces the count to 0.
module counter_tick_gen #(
    parameter int DIV_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             tick_o
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;
    logic             at_div;

    assign at_div = (cnt_q == div_i);
    assign tick_o = en_i && at_div;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = at_div ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/counter_sweep_ctrl.sv
// Sequencer that drives an up/down counter's enable/dir so the count sweeps
// between latched bounds lo/hi, once (SINGLE) or continuously (BOUNCE).
module counter_sweep_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int WIDTH = 3,
    parameter int DIV_W = 4,
    parameter int REV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             pause_i,
    input  logic             mode_i,
    input  logic [WIDTH-1:0] lo_i,
    input  logic [WIDTH-1:0] hi_i,
    input  logic [DIV_W-1:0] div_i,
    input  logic [WIDTH-1:0] count_i,
    output logic             enable_o,
    output logic             dir_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [REV_W-1:0] rev_cnt_o
);

    sweep_state_t     state_q, state_d;
    sweep_mode_t      mode_q, mode_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             dir_q, dir_d;
    logic             err_q, err_d;
    logic [REV_W-1:0] rev_q, rev_d;
    logic [REV_W-1:0] rev_inc;
    logic             step_en;
    logic             run;
    logic             tick;

    assign run     = (state_q == RUN_UP) || (state_q == RUN_DOWN);
    assign rev_inc = (&rev_q) ? rev_q : rev_q + 1'b1;

    // Prescaler only advances in a run cycle that is not overridden by stop
    // or pause; it is held at zero elsewhere so every run entry starts fresh.
    counter_tick_gen #(
        .DIV_W (DIV_W)
    ) u_tick_gen (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (!run),
        .en_i   (run && !stop_i && !pause_i),
        .div_i  (div_q),
        .tick_o (tick)
    );

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        div_d   = div_q;
        dir_d   = dir_q;
        err_d   = 1'b0;
        rev_d   = rev_q;
        step_en = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i && !stop_i) begin
                    if (lo_i <= hi_i) begin
                        lo_d   = lo_i;
                        hi_d   = hi_i;
                        div_d  = div_i;
                        mode_d = sweep_mode_t'(mode_i);
                        rev_d  = '0;
                        if (count_i > hi_i) begin
                            state_d = RUN_DOWN;
                            dir_d   = DIR_DOWN;
                        end else begin
                            state_d = RUN_UP;
                            dir_d   = DIR_UP;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            RUN_UP: begin
                if (stop_i) begin
                    state_d = IDLE;
                end else if (pause_i) begin
                    state_d = PAUSED;
                end else if (tick) begin
                    if (count_i < hi_q) begin
                        step_en = 1'b1;
                    end else begin
                        state_d = RUN_DOWN;
                        dir_d   = DIR_DOWN;
                        rev_d   = rev_inc;
                    end
                end
            end
            RUN_DOWN: begin
                if (stop_i) begin
                    state_d = IDLE;
                end else if (pause_i) begin
                    state_d = PAUSED;
                end else if (tick) begin
                    if (count_i > lo_q) begin
                        step_en = 1'b1;
                    end else if (mode_q == BOUNCE) begin
                        state_d = RUN_UP;
                        dir_d   = DIR_UP;
                        rev_d   = rev_inc;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            PAUSED: begin
                // dir_q still holds the direction of the run state we left.
                if (stop_i) begin
                    state_d = IDLE;
                end else if (!pause_i) begin
                    state_d = (dir_q == DIR_DOWN) ? RUN_DOWN : RUN_UP;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            mode_q  <= SINGLE;
            lo_q    <= '0;
            hi_q    <= '0;
            div_q   <= '0;
            dir_q   <= DIR_UP;
            err_q   <= 1'b0;
            rev_q   <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            div_q   <= div_d;
            dir_q   <= dir_d;
            err_q   <= err_d;
            rev_q   <= rev_d;
        end
    end

    // Reset wins over stepping in the same cycle so the counter is held.
    assign enable_o  = step_en && !rst;
    assign dir_o     = dir_q;
    assign busy_o    = run || (state_q == PAUSED);
    assign done_o    = (state_q == DONE);
    assign err_o     = err_q;
    assign rev_cnt_o = rev_q;

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// Bench for counter_sweep_ctrl driving a behavioural up/down counter; sweeps
// are predicted from leg/tick arithmetic and checked cycle by cycle.
module tb_counter_sweep_ctrl;

    localparam int WIDTH = 3;
    localparam int DIV_W = 4;
    localparam int REV_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start_i, stop_i, pause_i, mode_i;
    logic [WIDTH-1:0] lo_i, hi_i;
    logic [DIV_W-1:0] div_i;
    logic [WIDTH-1:0] count;
    logic             enable_o, dir_o, busy_o, done_o, err_o;
    logic [REV_W-1:0] rev_cnt_o;
    logic             cnt_load;
    logic [WIDTH-1:0] cnt_load_val;

    int tests_run    = 0;
    int tests_failed = 0;
    int exp_en[$];
    int exp_cnt[$];
    int exp_dir[$];
    int exp_rev;
    int exp_final;

    counter_sweep_ctrl #(
        .WIDTH (WIDTH),
        .DIV_W (DIV_W),
        .REV_W (REV_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start_i   (start_i),
        .stop_i    (stop_i),
        .pause_i   (pause_i),
        .mode_i    (mode_i),
        .lo_i      (lo_i),
        .hi_i      (hi_i),
        .div_i     (div_i),
        .count_i   (count),
        .enable_o  (enable_o),
        .dir_o     (dir_o),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .err_o     (err_o),
        .rev_cnt_o (rev_cnt_o)
    );

    always #5 clk = ~clk;

    // The controlled counter: loadable, steps on enable, dir=1 decrements.
    always @(posedge clk) begin
        if (cnt_load) count <= cnt_load_val;
        else if (enable_o) count <= dir_o ? count - 3'd1 : count + 3'd1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic load_count(input int v);
        @(negedge clk);
        cnt_load     = 1'b1;
        cnt_load_val = v[2:0];
        @(negedge clk);
        cnt_load     = 1'b0;
    endtask

    // Start in cycle N; returns just after the edge entering cycle N+1.
    task automatic do_start(input int lo, input int hi, input int div, input int mode);
        @(negedge clk);
        start_i = 1'b1;
        lo_i    = lo[2:0];
        hi_i    = hi[2:0];
        div_i   = div[3:0];
        mode_i  = mode[0];
        #1;
        check("idle_before_start", busy_o, 0);
        @(posedge clk);
        #1;
        start_i = 1'b0;
    endtask

    // A sweep is a chain of legs toward alternating bounds. Every position on a
    // leg costs one tick; the tick spent at the leg's end is a reversal (or, at
    // lo in single mode, the finish). Ticks arrive every div+1 cycles.
    task automatic build_model(input int spos, input int lo, input int hi,
                               input int div, input int mode, input int max_ticks);
        int  tstep[$];
        int  tdir[$];
        int  pos, cur, nrev;
        bit  dn;
        exp_en.delete();
        exp_cnt.delete();
        exp_dir.delete();
        pos = spos;
        dn  = (spos > hi);
        while (tstep.size() < max_ticks) begin
            if (!dn) begin
                for (int v = pos; v < hi; v++) begin
                    tstep.push_back(1);
                    tdir.push_back(0);
                end
                tstep.push_back(0);
                tdir.push_back(0);
                pos = hi;
                dn  = 1'b1;
            end else begin
                for (int v = pos; v > lo; v--) begin
                    tstep.push_back(1);
                    tdir.push_back(1);
                end
                tstep.push_back(0);
                tdir.push_back(1);
                pos = lo;
                dn  = 1'b0;
                if (mode == 0) break;
            end
        end
        while (tstep.size() > max_ticks) begin
            void'(tstep.pop_back());
            void'(tdir.pop_back());
        end
        nrev = 0;
        foreach (tstep[i]) if (tstep[i] == 0) nrev++;
        if (mode == 0) nrev--;
        cur = spos;
        foreach (tstep[i]) begin
            for (int k = 0; k <= div; k++) begin
                exp_cnt.push_back(cur);
                exp_en.push_back((k == div && tstep[i] == 1) ? 1 : 0);
                exp_dir.push_back(tdir[i]);
                if (k == div && tstep[i] == 1) cur = (tdir[i] == 1) ? cur - 1 : cur + 1;
            end
        end
        exp_rev   = nrev;
        exp_final = cur;
    endtask

    task automatic run_check(input int mode);
        for (int j = 0; j < exp_en.size(); j++) begin
            @(negedge clk);
            #1;
            check("enable", enable_o, exp_en[j]);
            check("count", count, exp_cnt[j]);
            check("dir", dir_o, exp_dir[j]);
            check("busy", busy_o, 1);
        end
        if (mode == 0) begin
            @(negedge clk);
            #1;
            check("done_pulse", done_o, 1);
            check("busy_in_done", busy_o, 0);
            check("rev_single", rev_cnt_o, exp_rev);
            check("count_final", count, exp_final);
            @(negedge clk);
            #1;
            check("done_cleared", done_o, 0);
            check("busy_idle", busy_o, 0);
        end else begin
            @(negedge clk);
            stop_i = 1'b1;
            #1;
            check("enable_on_stop", enable_o, 0);
            @(negedge clk);
            stop_i = 1'b0;
            #1;
            check("busy_after_stop", busy_o, 0);
            check("count_after_stop", count, exp_final);
            check("rev_bounce", rev_cnt_o, exp_rev);
        end
    endtask

    task automatic wait_for(input int cv, input int dv, output bit found);
        found = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (count == cv[2:0] && dir_o == dv[0] && busy_o) begin
                found = 1'b1;
                break;
            end
        end
        check("wait_found", found, 1);
    endtask

    initial begin
        bit found;
        int lo, hi, div, mode, spos, mt, tmp;
        rst = 1'b1; start_i = 1'b0; stop_i = 1'b0; pause_i = 1'b0; mode_i = 1'b0;
        lo_i = '0; hi_i = '0; div_i = '0; cnt_load = 1'b0; cnt_load_val = '0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_enable", enable_o, 0);
        check("rst_dir", dir_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_err", err_o, 0);
        check("rst_rev", rev_cnt_o, 0);
        @(negedge clk);
        rst = 1'b0;
        load_count(0);

        // Single sweep lo=2 hi=5 div=0 from 0
        build_model(0, 2, 5, 0, 0, 1000);
        do_start(2, 5, 0, 0);
        run_check(0);

        // Bounce lo=0 hi=7 div=2 through three turns
        load_count(0);
        build_model(0, 0, 7, 2, 1, 24);
        do_start(0, 7, 2, 1);
        run_check(1);

        // Pause for 5 cycles at count 3 going up, div=1
        do_start(0, 7, 1, 1);
        wait_for(3, 0, found);
        pause_i = 1'b1;
        #1;
        check("pause_enable", enable_o, 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            check("paused_enable", enable_o, 0);
            check("paused_count", count, 3);
            check("paused_busy", busy_o, 1);
        end
        @(negedge clk);
        pause_i = 1'b0;
        #1;
        check("release_enable", enable_o, 0);
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            #1;
            check("resume_enable", enable_o, (k == 2) ? 1 : 0);
            check("resume_count", count, 3);
        end
        @(negedge clk);
        #1;
        check("resume_step", count, 4);

        // Stop during RUN_DOWN at count 4
        wait_for(4, 1, found);
        stop_i = 1'b1;
        #1;
        check("stop_enable", enable_o, 0);
        @(negedge clk);
        stop_i = 1'b0;
        #1;
        check("stop_busy", busy_o, 0);
        check("stop_count", count, 4);
        check("stop_dir_held", dir_o, 1);

        // start and stop together
        @(negedge clk);
        start_i = 1'b1; stop_i = 1'b1; lo_i = 3'd0; hi_i = 3'd7;
        #1;
        @(negedge clk);
        start_i = 1'b0; stop_i = 1'b0;
        #1;
        check("ss_busy", busy_o, 0);
        check("ss_err", err_o, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            check("ss_enable", enable_o, 0);
            check("ss_count", count, 4);
        end

        // Rejected start lo=6 hi=2
        @(negedge clk);
        start_i = 1'b1; lo_i = 3'd6; hi_i = 3'd2;
        #1;
        check("err_not_yet", err_o, 0);
        @(negedge clk);
        start_i = 1'b0;
        #1;
        check("err_pulse", err_o, 1);
        check("err_busy", busy_o, 0);
        check("err_enable", enable_o, 0);
        @(negedge clk);
        #1;
        check("err_cleared", err_o, 0);
        check("err_enable2", enable_o, 0);

        // Reset mid-sweep at count 5, then restart from 5
        load_count(2);
        do_start(2, 6, 0, 0);
        wait_for(5, 0, found);
        rst = 1'b1;
        #1;
        check("rst_mid_enable", enable_o, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rstm_enable", enable_o, 0);
        check("rstm_dir", dir_o, 0);
        check("rstm_busy", busy_o, 0);
        check("rstm_done", done_o, 0);
        check("rstm_err", err_o, 0);
        check("rstm_rev", rev_cnt_o, 0);
        check("rstm_count", count, 5);
        build_model(5, 2, 6, 0, 0, 1000);
        do_start(2, 6, 0, 0);
        run_check(0);

        // Randomized sweeps
        for (int n = 0; n < 14; n++) begin
            lo   = $urandom_range(0, 7);
            hi   = $urandom_range(0, 7);
            if (lo > hi) begin tmp = lo; lo = hi; hi = tmp; end
            div  = $urandom_range(0, 3);
            mode = $urandom_range(0, 1);
            spos = $urandom_range(0, 7);
            mt   = (mode == 1) ? $urandom_range(4, 30) : 1000;
            load_count(spos);
            build_model(spos, lo, hi, div, mode, mt);
            do_start(lo, hi, div, mode);
            run_check(mode);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/counter_sweep_ctrl.md
Name: counter_sweep_ctrl

Overview:
- Sequencer for the team's up/down counter (WIDTH-bit, enable/dir controlled, dir=1 decrements).
- Drives the counter's enable and dir so it sweeps between programmable bounds lo/hi at a programmable step rate.
- Supports single-sweep and continuous-bounce modes, plus pause, stop and done/error reporting.
- Sits between the control/register logic and one counter instance; observes the counter value via count_i.

Parameters:
- WIDTH, 3, counter width; must match the controlled counter.
- DIV_W, 4, width of the step-rate divider.
- REV_W, 8, width of the reversal counter.

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- start_i  in  1  start pulse; sampled only in IDLE.
- stop_i  in  1  abort to IDLE.
- pause_i  in  1  level; freezes stepping while high.
- mode_i  in  1  0 = single sweep, 1 = continuous bounce; latched at start.
- lo_i  in  WIDTH  lower bound; latched at start.
- hi_i  in  WIDTH  upper bound; latched at start.
- div_i  in  DIV_W  step period minus 1; latched at start.
- count_i  in  WIDTH  present counter value.
- enable_o  out  1  to counter enable_i.
- dir_o  out  1  to counter dir_i; 0 = up, 1 = down.
- busy_o  out  1  high in RUN_UP, RUN_DOWN and PAUSED.
- done_o  out  1  one-cycle pulse on single-sweep completion.
- err_o  out  1  one-cycle pulse on a rejected start.
- rev_cnt_o  out  REV_W  reversals since last start; saturating.

Behaviour:
- Reset (synchronous, rst=1 at clock edge):
  - state=IDLE; enable_o=0, dir_o=0, busy_o=0, done_o=0, err_o=0, rev_cnt_o=0.
  - Latched config cleared; prescaler=0.
  - Applies mid-operation too; the counter itself is not touched.
- States: IDLE, RUN_UP, RUN_DOWN, PAUSED, DONE.
- Priority each cycle: rst > stop_i > pause_i > tick/bound logic. start_i is ignored outside IDLE.
- IDLE:
  - start_i=1, stop_i=0 and lo_i<=hi_i: latch lo, hi, div, mode; clear rev_cnt.
  - Then go to RUN_DOWN if count_i>hi_i, else RUN_UP.
  - start_i=1 with lo_i>hi_i: err_o=1 next cycle, stay IDLE.
  - start_i and stop_i together: stay IDLE, no error.
- Prescaler:
  - Counts 0..div and asserts tick when it equals div, then wraps to 0.
  - Cleared on entry to RUN_UP/RUN_DOWN from IDLE or PAUSED.
  - div=0 gives a tick every run cycle.
- RUN_UP:
  - On tick with count_i<hi: enable_o=1, dir_o=0 (combinational, same cycle). Counter steps at the next edge.
  - On tick with count_i>=hi: enable_o=0, move to RUN_DOWN, rev_cnt+1.
- RUN_DOWN:
  - On tick with count_i>lo: enable_o=1, dir_o=1.
  - On tick with count_i<=lo, bounce mode: go to RUN_UP, rev_cnt+1.
  - On tick with count_i<=lo, single mode: go to DONE; no increment.
- Stepping never wraps: bound comparisons use >= and <=, unsigned, and the controller never steps past hi or lo.
- lo==hi is legal. Single mode ends after one reversal; bounce mode alternates states without stepping.
- Start latency: start at cycle N, state RUN at N+1. First enable_o at cycle N+1+div.
- pause_i=1 in RUN_*: next state PAUSED with saved direction; enable_o=0 in that cycle. On release, return to the saved RUN state with the prescaler cleared.
- stop_i=1 in any non-IDLE state: enable_o=0 that cycle, next state IDLE; count is held.
- DONE: lasts one cycle with done_o=1, then IDLE.
- dir_o is registered and holds the last direction, including in PAUSED and IDLE.
- rev_cnt saturates at all ones.

Decomposition:
- Shared package counter_ctrl_pkg:
  - sweep_state_t enum (IDLE, RUN_UP, RUN_DOWN, PAUSED, DONE).
  - sweep_mode_t enum (SINGLE=0, BOUNCE=1).
  - DIR_UP=0 and DIR_DOWN=1 constants.
- One sub-module: counter_tick_gen (DIV_W prescaler with clear and enable, outputs tick).

Test Plan:
- WIDTH=3; counter reset to 0; lo=2, hi=5, div=0, single mode; start.
  -> count sequence 0,1,2,3,4,5,4,3,2; done_o one pulse; rev_cnt_o=1; busy_o falls after DONE.
- lo=0, hi=7, div=2, bounce mode.
  -> enable_o high exactly every 3rd cycle; count 0..7..0..7 with no wrap to 0 from 7; rev_cnt_o=3 after the third turn; dir_o toggles at each bound.
- Bounce mode, pause_i high for 5 cycles while count=3 going up.
  -> enable_o=0 and count held at 3; after release, next step 3->4 occurs div+1 cycles later.
- stop_i during RUN_DOWN at count 4.
  -> IDLE next cycle, count stays 4, busy_o=0.
- start_i with stop_i in the same cycle.
  -> stays IDLE.
- start with lo=6, hi=2.
  -> err_o one pulse, stays IDLE, enable_o never asserted.
- rst asserted mid-sweep at count 5 (lo=2, hi=6).
  -> all outputs zero the following cycle; next start from count 5 enters RUN_UP.
